// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game button front-end.
package simon_pkg;

    // Button encoder states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } enc_state_e;

    // Index of one of the four player buttons.
    typedef logic [1:0] btn_idx_t;

    // Converts a one-hot button vector to its index (highest set bit wins,
    // callers only use it on vectors already known to be one-hot).
    function automatic btn_idx_t onehot_to_idx(input logic [3:0] oh);
        btn_idx_t idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) begin
                idx = btn_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/simon_sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module simon_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture to settle metastability before use.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/simon_btn_encoder.sv
// Button front-end for the Simon game: synchronise, debounce, reject
// chords and emit exactly one btn_valid strobe per physical press.
module simon_btn_encoder
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 8,
    parameter int PULSE_TICKS    = 2
) (
    input  logic       clk_tick,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       enable,
    output logic       btn_valid,
    output logic [1:0] btn_val,
    output logic       busy,
    output logic       chord_err
);

    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_TICKS - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_TICKS - 1);

    logic [3:0] s;
    logic [3:0] idx_mask;

    enc_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    btn_idx_t   idx_q, idx_d;
    logic       btn_valid_q, btn_valid_d;
    btn_idx_t   btn_val_q, btn_val_d;
    logic       busy_q, busy_d;
    logic       chord_err_q, chord_err_d;

    simon_sync2 #(
        .WIDTH(4)
    ) u_sync (
        .clk_i(clk_tick),
        .rst_i(reset),
        .d_i  (btn_raw),
        .q_o  (s)
    );

    assign idx_mask = 4'b0001 << idx_q;

    // Next-state logic; outputs are derived from the next state so they
    // register on the same edge the FSM changes state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        chord_err_d = 1'b0;
        btn_val_d   = btn_val_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && (s != 4'b0000)) begin
                    cnt_d = 8'd0;
                    if ($onehot(s)) begin
                        idx_d   = onehot_to_idx(s);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        chord_err_d = 1'b1;
                        state_d     = ST_RELEASE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (s == idx_mask) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = ST_EMIT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if (s == 4'b0000) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d       = 8'd0;
                    chord_err_d = 1'b1;
                    state_d     = ST_RELEASE;
                end
            end
            ST_EMIT: begin
                // Pulse length is fixed; inputs are ignored here.
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                if (s != 4'b0000) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase

        btn_valid_d = (state_d == ST_EMIT);
        busy_d      = (state_d != ST_IDLE);
        if ((state_q != ST_EMIT) && (state_d == ST_EMIT)) begin
            btn_val_d = idx_q;
        end
    end

    // All encoder state and registered outputs.
    always_ff @(posedge clk_tick or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            idx_q       <= '0;
            btn_valid_q <= 1'b0;
            btn_val_q   <= '0;
            busy_q      <= 1'b0;
            chord_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            btn_valid_q <= btn_valid_d;
            btn_val_q   <= btn_val_d;
            busy_q      <= busy_d;
            chord_err_q <= chord_err_d;
        end
    end

    assign btn_valid = btn_valid_q;
    assign btn_val   = btn_val_q;
    assign busy      = busy_q;
    assign chord_err = chord_err_q;

endmodule
